// File: rtl/conv_seq_pkg.sv
// Shared constants for the convolution instruction sequencer: geometry, inst bit map, FSM states.
// The CONV_SEQ_ACC_EN macro (see conv_sequencer) enables the psum accumulation pass.
package conv_seq_pkg;

    localparam int unsigned row      = 8;
    localparam int unsigned col      = 8;
    localparam int unsigned k_dim    = 3;
    localparam int unsigned len_kij  = k_dim * k_dim;
    localparam int unsigned a_dim    = 6;
    localparam int unsigned len_nij  = a_dim * a_dim;
    localparam int unsigned o_dim    = a_dim - k_dim + 1;
    localparam int unsigned len_onij = o_dim * o_dim;
    localparam int unsigned addr_bw  = 11;

    localparam int unsigned inst_w = 34;
    localparam int unsigned cnt_w  = $clog2(len_nij + 2);
    localparam int unsigned kij_w  = 4;
    localparam int unsigned k_w    = $clog2(k_dim);
    localparam int unsigned o_w    = $clog2(o_dim);

    localparam int unsigned bit_acc      = 33;
    localparam int unsigned bit_cen_pmem = 32;
    localparam int unsigned bit_wen_pmem = 31;
    localparam int unsigned a_pmem_lsb   = 20;
    localparam int unsigned bit_cen_xmem = 19;
    localparam int unsigned bit_wen_xmem = 18;
    localparam int unsigned a_xmem_lsb   = 7;
    localparam int unsigned bit_ofifo_rd = 6;
    localparam int unsigned bit_ififo_wr = 5;
    localparam int unsigned bit_ififo_rd = 4;
    localparam int unsigned bit_l0_rd    = 3;
    localparam int unsigned bit_l0_wr    = 2;
    localparam int unsigned bit_execute  = 1;
    localparam int unsigned bit_load     = 0;

    // Both memories deselected and write-disabled, everything else quiet
    localparam logic [inst_w-1:0] inst_idle =
        (inst_w'(1) << bit_cen_pmem) | (inst_w'(1) << bit_wen_pmem) |
        (inst_w'(1) << bit_cen_xmem) | (inst_w'(1) << bit_wen_xmem);

    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_w_rd   = 3'd1;
    localparam logic [2:0] st_w_kern = 3'd2;
    localparam logic [2:0] st_x_rd   = 3'd3;
    localparam logic [2:0] st_exec   = 3'd4;
    localparam logic [2:0] st_drain  = 3'd5;
    localparam logic [2:0] st_acc    = 3'd6;
    localparam logic [2:0] st_done   = 3'd7;

endpackage

// File: rtl/conv_seq_if.sv
// Host/core-facing signal bundle of the convolution sequencer.
interface conv_seq_if;
    import conv_seq_pkg::*;

    logic              start;
    logic              ofifo_valid;
    logic [inst_w-1:0] inst;
    logic              busy;
    logic              done;
    logic [kij_w-1:0]  kij_idx;

    modport master (output start, ofifo_valid, input inst, busy, done, kij_idx);
    modport slave  (input start, ofifo_valid, output inst, busy, done, kij_idx);
endinterface

// File: rtl/conv_addr_gen.sv
// Nested ox/oy/kx/ky counters for the accumulation pass: psum read address and output address.
module conv_addr_gen
    import conv_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               step,
    output logic [addr_bw-1:0] rd_addr_c,
    output logic [addr_bw-1:0] wr_addr_c,
    output logic               wr_phase,
    output logic               last_c
);

    logic [k_w-1:0] kx, ky;
    logic [o_w-1:0] ox, oy;

    // kx fastest, then ky; after the last kernel tap one write cycle, then advance ox/oy
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            kx       <= '0;
            ky       <= '0;
            ox       <= '0;
            oy       <= '0;
            wr_phase <= 1'b0;
        end else if (step) begin
            if (wr_phase) begin
                wr_phase <= 1'b0;
                if (ox == o_w'(o_dim - 1)) begin
                    ox <= '0;
                    oy <= oy + o_w'(1);
                end else begin
                    ox <= ox + o_w'(1);
                end
            end else if (kx == k_w'(k_dim - 1)) begin
                kx <= '0;
                if (ky == k_w'(k_dim - 1)) begin
                    ky       <= '0;
                    wr_phase <= 1'b1;
                end else begin
                    ky <= ky + k_w'(1);
                end
            end else begin
                kx <= kx + k_w'(1);
            end
        end
    end

    assign rd_addr_c = (addr_bw'(ky) * addr_bw'(k_dim) + addr_bw'(kx)) * addr_bw'(len_nij)
                     + (addr_bw'(oy) + addr_bw'(ky)) * addr_bw'(a_dim)
                     + addr_bw'(ox) + addr_bw'(kx);
    assign wr_addr_c = addr_bw'(len_kij * len_nij) + addr_bw'(oy) * addr_bw'(o_dim) + addr_bw'(ox);
    assign last_c    = wr_phase && (ox == o_w'(o_dim - 1)) && (oy == o_w'(o_dim - 1));

endmodule

// File: rtl/conv_sequencer.sv
// Instruction sequencer for one 2D convolution layer on core.
// Define CONV_SEQ_ACC_EN to build the final psum accumulation pass (ACC state).
module conv_sequencer
    import conv_seq_pkg::*;
(
    input logic       clk,
    input logic       reset,
    conv_seq_if.slave bus
);

    logic [2:0]        state, state_nxt;
    logic [cnt_w-1:0]  cnt, cnt_nxt;
    logic [kij_w-1:0]  kij, kij_nxt;
    logic [inst_w-1:0] inst_q, inst_nxt;
    logic              busy_q, done_q;

`ifdef CONV_SEQ_ACC_EN
    logic [addr_bw-1:0] acc_rd_addr_c, acc_wr_addr_c;
    logic               acc_wr, acc_last_c;

    conv_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clr       (state != st_acc),
        .step      (state == st_acc),
        .rd_addr_c (acc_rd_addr_c),
        .wr_addr_c (acc_wr_addr_c),
        .wr_phase  (acc_wr),
        .last_c    (acc_last_c)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= st_idle;
            cnt    <= '0;
            kij    <= '0;
            inst_q <= inst_idle;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            kij    <= kij_nxt;
            inst_q <= inst_nxt;
            busy_q <= (state != st_idle) && (state != st_done);
            done_q <= (state == st_done);
        end
    end

    // Next state plus the instruction word to be registered on the coming edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        kij_nxt   = kij;
        inst_nxt  = inst_idle;
        case (state)
            st_idle: begin
                if (bus.start) begin
                    state_nxt = st_w_rd;
                    cnt_nxt   = '0;
                    kij_nxt   = '0;
                end
            end
            st_w_rd: begin
                if (cnt < cnt_w'(col)) begin
                    inst_nxt[bit_cen_xmem]          = 1'b0;
                    inst_nxt[a_xmem_lsb +: addr_bw] = addr_bw'(len_nij)
                        + addr_bw'(kij) * addr_bw'(col) + addr_bw'(cnt);
                end
                if (cnt != '0) inst_nxt[bit_l0_wr] = 1'b1;
                if (cnt == cnt_w'(col)) begin
                    state_nxt = st_w_kern;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + cnt_w'(1);
                end
            end
            st_w_kern: begin
                // col load cycles, then row quiet cycles while weights settle
                if (cnt < cnt_w'(col)) begin
                    inst_nxt[bit_l0_rd] = 1'b1;
                    inst_nxt[bit_load]  = 1'b1;
                end
                if (cnt == cnt_w'(col + row - 1)) begin
                    state_nxt = st_x_rd;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + cnt_w'(1);
                end
            end
            st_x_rd: begin
                if (cnt < cnt_w'(len_nij)) begin
                    inst_nxt[bit_cen_xmem]          = 1'b0;
                    inst_nxt[a_xmem_lsb +: addr_bw] = addr_bw'(cnt);
                end
                if (cnt != '0) inst_nxt[bit_l0_wr] = 1'b1;
                if (cnt == cnt_w'(len_nij)) begin
                    state_nxt = st_exec;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + cnt_w'(1);
                end
            end
            st_exec: begin
                inst_nxt[bit_l0_rd]   = 1'b1;
                inst_nxt[bit_execute] = 1'b1;
                if (cnt == cnt_w'(len_nij - 1)) begin
                    state_nxt = st_drain;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + cnt_w'(1);
                end
            end
            st_drain: begin
                if (bus.ofifo_valid) begin
                    inst_nxt[bit_ofifo_rd]          = 1'b1;
                    inst_nxt[bit_cen_pmem]          = 1'b0;
                    inst_nxt[bit_wen_pmem]          = 1'b0;
                    inst_nxt[a_pmem_lsb +: addr_bw] = addr_bw'(kij) * addr_bw'(len_nij) + addr_bw'(cnt);
                    if (cnt == cnt_w'(len_nij - 1)) begin
                        cnt_nxt = '0;
                        if (kij == kij_w'(len_kij - 1)) begin
`ifdef CONV_SEQ_ACC_EN
                            state_nxt = st_acc;
`else
                            state_nxt = st_done;
`endif
                        end else begin
                            kij_nxt   = kij + kij_w'(1);
                            state_nxt = st_w_rd;
                        end
                    end else begin
                        cnt_nxt = cnt + cnt_w'(1);
                    end
                end
            end
`ifdef CONV_SEQ_ACC_EN
            st_acc: begin
                inst_nxt[bit_cen_pmem] = 1'b0;
                if (acc_wr) begin
                    inst_nxt[bit_wen_pmem]          = 1'b0;
                    inst_nxt[a_pmem_lsb +: addr_bw] = acc_wr_addr_c;
                    if (acc_last_c) state_nxt = st_done;
                end else begin
                    inst_nxt[bit_acc]               = 1'b1;
                    inst_nxt[a_pmem_lsb +: addr_bw] = acc_rd_addr_c;
                end
            end
`endif
            st_done: begin
                state_nxt = st_idle;
            end
            default: begin
                state_nxt = st_idle;
            end
        endcase
    end

    assign bus.inst    = inst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.kij_idx = kij;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: expected non-idle inst words are queued per layer and
// popped in order as the DUT emits them. Honors CONV_SEQ_ACC_EN like the RTL.
module tb_conv_sequencer;
    import conv_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;

    conv_seq_if bus ();

    conv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned       errors = 0;
    int unsigned       checks = 0;
    logic [inst_w-1:0] exp_q[$];
    bit                mon_en = 1'b0;
    bit                toggle_valid = 1'b0;
    int unsigned       done_cnt = 0;
    logic              valid_at_edge;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected non-idle instruction stream of one layer, built from the memory map
    function automatic void push_layer();
        logic [inst_w-1:0] w;
        for (int k = 0; k < int'(len_kij); k++) begin
            for (int t = 0; t <= int'(col); t++) begin
                w = inst_idle;
                if (t < int'(col)) begin
                    w[bit_cen_xmem] = 1'b0;
                    w[a_xmem_lsb +: addr_bw] = addr_bw'(int'(len_nij) + k * int'(col) + t);
                end
                if (t > 0) w[bit_l0_wr] = 1'b1;
                exp_q.push_back(w);
            end
            for (int t = 0; t < int'(col); t++) begin
                w = inst_idle;
                w[bit_l0_rd] = 1'b1;
                w[bit_load]  = 1'b1;
                exp_q.push_back(w);
            end
            for (int t = 0; t <= int'(len_nij); t++) begin
                w = inst_idle;
                if (t < int'(len_nij)) begin
                    w[bit_cen_xmem] = 1'b0;
                    w[a_xmem_lsb +: addr_bw] = addr_bw'(t);
                end
                if (t > 0) w[bit_l0_wr] = 1'b1;
                exp_q.push_back(w);
            end
            for (int t = 0; t < int'(len_nij); t++) begin
                w = inst_idle;
                w[bit_l0_rd]   = 1'b1;
                w[bit_execute] = 1'b1;
                exp_q.push_back(w);
            end
            for (int t = 0; t < int'(len_nij); t++) begin
                w = inst_idle;
                w[bit_ofifo_rd] = 1'b1;
                w[bit_cen_pmem] = 1'b0;
                w[bit_wen_pmem] = 1'b0;
                w[a_pmem_lsb +: addr_bw] = addr_bw'(k * int'(len_nij) + t);
                exp_q.push_back(w);
            end
        end
`ifdef CONV_SEQ_ACC_EN
        for (int oy = 0; oy < int'(o_dim); oy++) begin
            for (int ox = 0; ox < int'(o_dim); ox++) begin
                for (int ky = 0; ky < int'(k_dim); ky++) begin
                    for (int kx = 0; kx < int'(k_dim); kx++) begin
                        w = inst_idle;
                        w[bit_acc]      = 1'b1;
                        w[bit_cen_pmem] = 1'b0;
                        w[a_pmem_lsb +: addr_bw] = addr_bw'((ky * int'(k_dim) + kx) * int'(len_nij)
                                                   + (oy + ky) * int'(a_dim) + ox + kx);
                        exp_q.push_back(w);
                    end
                end
                w = inst_idle;
                w[bit_cen_pmem] = 1'b0;
                w[bit_wen_pmem] = 1'b0;
                w[a_pmem_lsb +: addr_bw] = addr_bw'(int'(len_kij * len_nij) + oy * int'(o_dim) + ox);
                exp_q.push_back(w);
            end
        end
`endif
    endfunction

    initial begin
        bus.ofifo_valid = 1'b1;
        forever begin
            @(negedge clk);
            bus.ofifo_valid = toggle_valid ? ~bus.ofifo_valid : 1'b1;
        end
    end

    // Monitor: every non-idle word must be the next expected one
    always @(posedge clk) begin
        valid_at_edge = bus.ofifo_valid;
        #1;
        if (mon_en && !reset) begin
            if (bus.inst !== inst_idle) begin
                if (exp_q.size() == 0) check_eq("extra_inst", 64'(bus.inst), 64'(inst_idle));
                else check_eq("inst", 64'(bus.inst), 64'(exp_q.pop_front()));
                if (bus.inst[bit_ofifo_rd]) check_eq("rd_needs_valid", 64'(valid_at_edge), 64'd1);
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic run_layer(input bit toggle, input bit poke_start);
        int n;
        int exp_cycles;
`ifdef CONV_SEQ_ACC_EN
        exp_cycles = int'(len_kij) * (int'(col) + 1 + int'(col + row) + int'(len_nij) + 1
                     + 2 * int'(len_nij)) + int'(len_onij * (len_kij + 1)) + 1;
`else
        exp_cycles = int'(len_kij) * (int'(col) + 1 + int'(col + row) + int'(len_nij) + 1
                     + 2 * int'(len_nij)) + 1;
`endif
        exp_q.delete();
        push_layer();
        toggle_valid = toggle;
        done_cnt = 0;
        mon_en = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("busy_at_accept", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("busy_after", 64'(bus.busy), 64'd1);
        check_eq("first_xaddr", 64'(bus.inst[a_xmem_lsb +: addr_bw]), 64'(len_nij));
        n = 1;
        while (!bus.done && n < 6000) begin
            if (poke_start && n == 50) bus.start = 1'b1;
            if (poke_start && n == 51) bus.start = 1'b0;
            if (n == 100) check_eq("busy_mid", 64'(bus.busy), 64'd1);
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("done_seen", 64'(bus.done), 64'd1);
        if (!toggle) check_eq("layer_cycles", 64'(n), 64'(exp_cycles));
        check_eq("busy_at_done", 64'(bus.busy), 64'd0);
        check_eq("words_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check_eq("done_pulse_1cyc", 64'(bus.done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_count", 64'(done_cnt), 64'd1);
        mon_en = 1'b0;
        toggle_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_inst", 64'(bus.inst), 64'(inst_idle));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_inst", 64'(bus.inst), 64'(inst_idle));
        check_eq("idle_busy", 64'(bus.busy), 64'd0);
        check_eq("idle_done", 64'(bus.done), 64'd0);
        check_eq("idle_kij", 64'(bus.kij_idx), 64'd0);

        run_layer(1'b0, 1'b1);
        run_layer(1'b1, 1'b0);

        // Reset in the middle of EXEC for kij=3
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.kij_idx == kij_w'(3) && bus.inst[bit_execute]) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("reach_exec_kij3", 64'(n < 3000), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_inst", 64'(bus.inst), 64'(inst_idle));
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_kij", 64'(bus.kij_idx), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run_layer(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
